// File: rtl/btb_dyn_predictor.sv
// Direct-mapped writable BTB with 2-bit direction counters and a one-entry-per-cycle flush sweep.
// Optional BTB_STATS_EN adds lookup/hit/mispredict counters.
module btb_dyn_predictor #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned DEPTH    = 32,
  parameter logic [1:0]  CTR_INIT = 2'b10
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [XLEN-1:0] fpc,
  output logic [XLEN-1:0] next_pc,
  output logic            pred,
  output logic            btb_hit,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] epc,
  input  logic [XLEN-1:0] upd_target,
  input  logic            branch_taken,
  input  logic            flush_req,
  output logic            flush_busy
`ifdef BTB_STATS_EN
  ,
  output logic [31:0]     lookup_cnt,
  output logic [31:0]     hit_cnt,
  output logic [31:0]     mispred_cnt
`endif
);

  localparam int unsigned IDX  = $clog2(DEPTH);
  localparam int unsigned TAGW = XLEN - IDX - 2;

  typedef enum logic {S_IDLE, S_SWEEP} state_t;

  state_t           state_q, state_d;
  logic [IDX-1:0]   cnt_q, cnt_d;
  logic [DEPTH-1:0] valid_q;
  logic [1:0]       ctr_q [DEPTH];
  logic [TAGW-1:0]  tag_q [DEPTH];
  logic [XLEN-1:0]  tgt_q [DEPTH];

  logic [IDX-1:0]   fidx, eidx;
  logic [TAGW-1:0]  ftag, etag;
  logic             e_hit, upd_en;
  logic [1:0]       ctr_d;
  logic             unused_pc_lsbs;

  assign fidx = fpc[IDX+1:2];
  assign ftag = fpc[XLEN-1:IDX+2];
  assign eidx = epc[IDX+1:2];
  assign etag = epc[XLEN-1:IDX+2];
  assign unused_pc_lsbs = ^epc[1:0];

  assign flush_busy = (state_q == S_SWEEP);
  assign btb_hit    = valid_q[fidx] && (tag_q[fidx] == ftag) && !flush_busy;
  assign pred       = btb_hit && ctr_q[fidx][1];
  assign next_pc    = pred ? tgt_q[fidx] : fpc + XLEN'(4);

  // A flush request in the same cycle as an update takes priority and drops it.
  assign e_hit  = valid_q[eidx] && (tag_q[eidx] == etag);
  assign upd_en = upd_valid && (state_q == S_IDLE) && !flush_req;

  always_comb begin
    ctr_d = ctr_q[eidx];
    if (branch_taken) begin
      if (ctr_q[eidx] != 2'b11) ctr_d = ctr_q[eidx] + 2'd1;
    end else begin
      if (ctr_q[eidx] != 2'b00) ctr_d = ctr_q[eidx] - 2'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (flush_req) begin
          state_d = S_SWEEP;
          cnt_d   = '0;
        end
      end
      S_SWEEP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == IDX'(DEPTH - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) ctr_q[i] <= CTR_INIT;
    end else if (flush_busy) begin
      valid_q[cnt_q] <= 1'b0;
    end else if (upd_en) begin
      if (e_hit) begin
        ctr_q[eidx] <= ctr_d;
      end else if (branch_taken) begin
        valid_q[eidx] <= 1'b1;
        ctr_q[eidx]   <= CTR_INIT;
      end
    end
  end

  // Tag is rewritten on a taken hit too; it is unchanged there, so one write path covers both.
  always_ff @(posedge clk) begin
    if (upd_en && branch_taken) begin
      tag_q[eidx] <= etag;
      tgt_q[eidx] <= upd_target;
    end
  end

`ifdef BTB_STATS_EN
  logic [31:0] lookup_q, hit_q, mis_q;
  logic        e_pred;

  assign e_pred = e_hit && ctr_q[eidx][1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lookup_q <= '0;
      hit_q    <= '0;
      mis_q    <= '0;
    end else begin
      if (!flush_busy) lookup_q <= lookup_q + 32'd1;
      if (btb_hit) hit_q <= hit_q + 32'd1;
      if (upd_valid && (e_pred != branch_taken)) mis_q <= mis_q + 32'd1;
    end
  end

  assign lookup_cnt  = lookup_q;
  assign hit_cnt     = hit_q;
  assign mispred_cnt = mis_q;
`endif

endmodule

// File: tb/tb_btb_dyn_predictor.sv
// Directed, table-driven bench for btb_dyn_predictor (DEPTH=32); stats checks only under BTB_STATS_EN.
module tb_btb_dyn_predictor;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] fpc = '0;
  logic [31:0] next_pc;
  logic        pred, btb_hit;
  logic        upd_valid = 1'b0;
  logic [31:0] epc = '0;
  logic [31:0] upd_target = '0;
  logic        branch_taken = 1'b0;
  logic        flush_req = 1'b0;
  logic        flush_busy;
`ifdef BTB_STATS_EN
  logic [31:0] lookup_cnt, hit_cnt, mispred_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  btb_dyn_predictor #(.XLEN(32), .DEPTH(32), .CTR_INIT(2'b10)) dut (
    .clk(clk), .rstn(rstn), .fpc(fpc), .next_pc(next_pc), .pred(pred), .btb_hit(btb_hit),
    .upd_valid(upd_valid), .epc(epc), .upd_target(upd_target), .branch_taken(branch_taken),
    .flush_req(flush_req), .flush_busy(flush_busy)
`ifdef BTB_STATS_EN
    , .lookup_cnt(lookup_cnt), .hit_cnt(hit_cnt), .mispred_cnt(mispred_cnt)
`endif
  );

  typedef struct {
    bit          is_upd;
    logic [31:0] addr;
    logic [31:0] tgt;
    logic        tk;
    logic        exp_hit;
    logic        exp_pred;
    logic [31:0] exp_npc;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] a, input logic [31:0] t, input logic tk);
    upd_valid = 1'b1; epc = a; upd_target = t; branch_taken = tk;
    step();
    upd_valid = 1'b0;
  endtask

  task automatic look(input string nm, input logic [31:0] a, input logic h, input logic p,
                      input logic [31:0] npc);
    fpc = a;
    #1;
    chk({nm, ".hit"}, 32'(btb_hit), 32'(h));
    chk({nm, ".pred"}, 32'(pred), 32'(p));
    chk({nm, ".npc"}, next_pc, npc);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step();
    step();
    rstn = 1'b1;
    step();
  endtask

  initial begin
    int busy_cycles;
    int extra_busy;

    // ctr sequence at 0x28: 10 -> 01 -> 00 -> 01 -> 10 -> 11 -> 11 -> 10 -> 01
    vq.push_back('{0, 32'h28, 0, 0, 0, 0, 32'h2C});
    vq.push_back('{1, 32'h28, 32'h30, 1, 0, 0, 0});
    vq.push_back('{0, 32'h28, 0, 0, 1, 1, 32'h30});
    vq.push_back('{1, 32'h28, 32'h30, 0, 0, 0, 0});
    vq.push_back('{0, 32'h28, 0, 0, 1, 0, 32'h2C});
    vq.push_back('{1, 32'h28, 32'h30, 0, 0, 0, 0});
    vq.push_back('{0, 32'h28, 0, 0, 1, 0, 32'h2C});
    vq.push_back('{1, 32'h28, 32'h30, 1, 0, 0, 0});
    vq.push_back('{0, 32'h28, 0, 0, 1, 0, 32'h2C});
    vq.push_back('{1, 32'h28, 32'h30, 1, 0, 0, 0});
    vq.push_back('{0, 32'h28, 0, 0, 1, 1, 32'h30});
    vq.push_back('{1, 32'h28, 32'h30, 1, 0, 0, 0});
    vq.push_back('{1, 32'h28, 32'h30, 1, 0, 0, 0});
    vq.push_back('{1, 32'h28, 32'h30, 0, 0, 0, 0});
    vq.push_back('{0, 32'h28, 0, 0, 1, 1, 32'h30});
    vq.push_back('{1, 32'h28, 32'h30, 0, 0, 0, 0});
    vq.push_back('{0, 32'h28, 0, 0, 1, 0, 32'h2C});
    // alias 0xA8 shares index 10 with 0x28
    vq.push_back('{0, 32'hA8, 0, 0, 0, 0, 32'hAC});
    vq.push_back('{1, 32'hA8, 32'h100, 1, 0, 0, 0});
    vq.push_back('{0, 32'hA8, 0, 0, 1, 1, 32'h100});
    vq.push_back('{0, 32'h28, 0, 0, 0, 0, 32'h2C});
    vq.push_back('{1, 32'hA8, 32'h200, 1, 0, 0, 0});
    vq.push_back('{0, 32'hA8, 0, 0, 1, 1, 32'h200});
    // miss + not taken allocates nothing
    vq.push_back('{1, 32'h40, 32'h80, 0, 0, 0, 0});
    vq.push_back('{0, 32'h40, 0, 0, 0, 0, 32'h44});
    vq.push_back('{0, 32'hFFFF_FFFC, 0, 0, 0, 0, 32'h0});

    do_reset();
    chk("reset.busy", 32'(flush_busy), 32'h0);

    foreach (vq[i]) begin
      if (vq[i].is_upd) upd(vq[i].addr, vq[i].tgt, vq[i].tk);
      else look($sformatf("vec%0d", i), vq[i].addr, vq[i].exp_hit, vq[i].exp_pred, vq[i].exp_npc);
    end

    // No bypass: lookup during the update cycle sees the old (empty) entry.
    fpc = 32'h50;
    upd_valid = 1'b1; epc = 32'h50; upd_target = 32'h60; branch_taken = 1'b1;
    #1;
    chk("nobyp.before", 32'(btb_hit), 32'h0);
    step();
    upd_valid = 1'b0;
    look("nobyp.after", 32'h50, 1, 1, 32'h60);

    // Flush sweep: entries at indices 28..31, update on flush_req cycle and mid-sweep dropped.
    for (int k = 0; k < 4; k++) upd(32'h170 + 32'(4 * k), 32'h400 + 32'(k), 1'b1);
    look("prefl.17C", 32'h17C, 1, 1, 32'h403);
    flush_req = 1'b1;
    upd_valid = 1'b1; epc = 32'h60; upd_target = 32'h500; branch_taken = 1'b1;
    step();
    flush_req = 1'b0;
    upd_valid = 1'b0;
    chk("flush.busy_rise", 32'(flush_busy), 32'h1);
    look("sweep.17C", 32'h17C, 0, 0, 32'h180);
    busy_cycles = 0;
    while (flush_busy && busy_cycles < 100) begin
      if (busy_cycles == 3) begin
        upd_valid = 1'b1; epc = 32'h200; upd_target = 32'h600; branch_taken = 1'b1;
      end
      step();
      upd_valid = 1'b0;
      busy_cycles++;
    end
    chk("flush.cycles", 32'(busy_cycles), 32'd32);
    for (int k = 0; k < 4; k++)
      look($sformatf("postfl%0d", k), 32'h170 + 32'(4 * k), 0, 0, 32'h174 + 32'(4 * k));
    look("postfl.midupd", 32'h200, 0, 0, 32'h204);
    look("postfl.requpd", 32'h60, 0, 0, 32'h64);

    // Reset at sweep cycle 5.
    upd(32'h17C, 32'h700, 1'b1);
    upd(32'h28, 32'h30, 1'b1);
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    repeat (5) step();
    chk("midrst.busy_before", 32'(flush_busy), 32'h1);
    rstn = 1'b0;
    #1;
    chk("midrst.busy", 32'(flush_busy), 32'h0);
    look("midrst.28", 32'h28, 0, 0, 32'h2C);
    step();
    rstn = 1'b1;
    extra_busy = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (flush_busy) extra_busy++;
    end
    chk("midrst.no_sweep", 32'(extra_busy), 32'h0);
    look("midrst.17C", 32'h17C, 0, 0, 32'h180);
    look("midrst.wrap", 32'hFFFF_FFFC, 0, 0, 32'h0);

`ifdef BTB_STATS_EN
    fpc = 32'h0;
    rstn = 1'b0;
    step();
    chk("st.rst_lookup", lookup_cnt, 32'd0);
    rstn = 1'b1;
    #1;
    upd(32'h28, 32'h30, 1'b1);
    upd(32'h28, 32'h30, 1'b0);
    fpc = 32'h28;
    repeat (3) step();
    fpc = 32'h0;
    repeat (5) step();
    chk("st.lookup", lookup_cnt, 32'd10);
    chk("st.hit", hit_cnt, 32'd3);
    chk("st.mispred", mispred_cnt, 32'd2);
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    busy_cycles = 0;
    while (flush_busy && busy_cycles < 100) begin
      step();
      busy_cycles++;
    end
    chk("st.fl_lookup", lookup_cnt, 32'd11);
    chk("st.fl_hit", hit_cnt, 32'd3);
    chk("st.fl_mispred", mispred_cnt, 32'd2);
    rstn = 1'b0;
    #1;
    chk("st.r_lookup", lookup_cnt, 32'd0);
    chk("st.r_hit", hit_cnt, 32'd0);
    chk("st.r_mispred", mispred_cnt, 32'd0);
    step();
    rstn = 1'b1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
